// File: rtl/spi_sclk_gen_if.sv
// Control/status bundle between an SPI shift-register controller and the SCLK generator.
interface spi_sclk_gen_if #(
  parameter int unsigned DIV_W = 8,
  parameter int unsigned CNT_W = 6
);
  logic [DIV_W-1:0] div_half;
  logic             cpol;
  logic             cpha;
  logic [CNT_W-1:0] nbits;
  logic             start;
  logic             abort;
  logic             busy;
  logic             done;
  logic             sclk;
  logic             lead_edge;
  logic             trail_edge;
  logic             sample_stb;
  logic             shift_stb;

  modport master (
    output div_half, cpol, cpha, nbits, start, abort,
    input  busy, done, sclk, lead_edge, trail_edge, sample_stb, shift_stb
  );

  modport slave (
    input  div_half, cpol, cpha, nbits, start, abort,
    output busy, done, sclk, lead_edge, trail_edge, sample_stb, shift_stb
  );
endinterface

// File: rtl/spi_sclk_gen.sv
// Programmable SPI serial-clock generator: runtime divisor, CPOL/CPHA, burst length,
// start/busy/done handshake and abort. All outputs are registered in the clk domain.
module spi_sclk_gen #(
  parameter int unsigned DIV_W = 8,
  parameter int unsigned CNT_W = 6
) (
  input  logic          clk,
  input  logic          rst,
  spi_sclk_gen_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StGuard} state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W:0]   ecnt_q, ecnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             cpol_q, cpol_d;
  logic             cpha_q, cpha_d;
  logic [CNT_W-1:0] nbits_q, nbits_d;
  logic             sclk_q, sclk_d;
  logic             lead_q, lead_d;
  logic             trail_q, trail_d;
  logic             sample_q, sample_d;
  logic             shift_q, shift_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             start_ok;
  logic             wrap;
  logic [CNT_W:0]   ecnt_inc;
  logic [CNT_W:0]   edges_total;
  logic [DIV_W-1:0] hcnt_nxt;

  // abort in the same idle cycle as start suppresses the start
  assign start_ok    = bus.start && !bus.abort && (bus.nbits != '0);
  assign wrap        = (hcnt_q == div_q);
  assign ecnt_inc    = ecnt_q + 1'b1;
  assign edges_total = {nbits_q, 1'b0};
  assign hcnt_nxt    = wrap ? '0 : hcnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      hcnt_q   <= '0;
      ecnt_q   <= '0;
      div_q    <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      nbits_q  <= '0;
      sclk_q   <= 1'b0;
      lead_q   <= 1'b0;
      trail_q  <= 1'b0;
      sample_q <= 1'b0;
      shift_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      ecnt_q   <= ecnt_d;
      div_q    <= div_d;
      cpol_q   <= cpol_d;
      cpha_q   <= cpha_d;
      nbits_q  <= nbits_d;
      sclk_q   <= sclk_d;
      lead_q   <= lead_d;
      trail_q  <= trail_d;
      sample_q <= sample_d;
      shift_q  <= shift_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_ok) state_d = StRun;
      StRun: begin
        if (bus.abort)                           state_d = StIdle;
        else if (wrap && ecnt_inc == edges_total) state_d = StGuard;
      end
      StGuard: if (bus.abort || wrap) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    hcnt_d  = hcnt_q;
    ecnt_d  = ecnt_q;
    div_d   = div_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    nbits_d = nbits_q;
    sclk_d  = sclk_q;
    lead_d  = 1'b0;
    trail_d = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        sclk_d = bus.cpol;
        busy_d = 1'b0;
        if (start_ok) begin
          div_d   = bus.div_half;
          cpol_d  = bus.cpol;
          cpha_d  = bus.cpha;
          nbits_d = bus.nbits;
          hcnt_d  = '0;
          ecnt_d  = '0;
          busy_d  = 1'b1;
        end
      end
      StRun: begin
        if (bus.abort) begin
          sclk_d = cpol_q;
          busy_d = 1'b0;
        end else begin
          hcnt_d = hcnt_nxt;
          if (wrap) begin
            sclk_d  = ~sclk_q;
            ecnt_d  = ecnt_inc;
            // edges numbered from 1: odd edges leave the idle level
            lead_d  = ~ecnt_q[0];
            trail_d = ecnt_q[0];
          end
        end
      end
      StGuard: begin
        if (bus.abort) begin
          sclk_d = cpol_q;
          busy_d = 1'b0;
        end else begin
          hcnt_d = hcnt_nxt;
          if (wrap) begin
            busy_d = 1'b0;
            done_d = 1'b1;
          end
        end
      end
      default: begin
        sclk_d = cpol_q;
        busy_d = 1'b0;
      end
    endcase
    sample_d = cpha_q ? trail_d : lead_d;
    shift_d  = cpha_q ? lead_d : trail_d;
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.sclk       = sclk_q;
  assign bus.lead_edge  = lead_q;
  assign bus.trail_edge = trail_q;
  assign bus.sample_stb = sample_q;
  assign bus.shift_stb  = shift_q;

endmodule

// File: doc/spi_sclk_gen.md
# spi_sclk_gen

- Programmable SPI serial-clock generator for the AFE4403 SPI path.
- Replaces the fixed divide-by-constant clock divider: runtime half-period divisor, CPOL/CPHA modes, burst length in bits, start/busy/done handshake, abort.
- Drives SCLK and per-edge sample/shift strobes to the SPI shift-register logic, all in the system clock domain.

## Interface

Parameters:
- DIV_W, 8, width of half-period divisor
- CNT_W, 6, width of bit-count field (max burst 2^CNT_W-1 bits)

Ports:
- clk  in  1  system clock (AFE4403 clock domain)
- rst  in  1  synchronous, active-high reset
- div_half  in  DIV_W  SCLK half-period minus 1, in clk cycles. Example: 9 gives 100 MHz to 5 MHz.
- cpol  in  1  SCLK idle level
- cpha  in  1  clock phase. 0: sample on leading edge. 1: sample on trailing edge.
- nbits  in  CNT_W  bits per burst
- start  in  1  one-cycle request to begin a burst
- abort  in  1  terminate the current burst immediately
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse at normal burst completion
- sclk  out  1  serial clock, registered
- lead_edge  out  1  pulse in the cycle sclk first shows a leading (away-from-idle) edge
- trail_edge  out  1  pulse in the cycle sclk first shows a trailing (back-to-idle) edge
- sample_stb  out  1  pulse: sample MISO. Equals lead_edge when cpha=0, trail_edge when cpha=1.
- shift_stb  out  1  pulse: drive next MOSI bit. The other edge of the pair.

## Operation

- States: IDLE, RUN, GUARD.
- Reset: state IDLE; busy, done, all strobes = 0; sclk = 0; internal counters = 0.
- IDLE:
  - sclk <= cpol input every cycle, so it tracks cpol one cycle later.
  - start=1 with nbits!=0: latch div_half, cpol, cpha, nbits; half-counter <= 0; edge counter <= 0; go to RUN; busy <= 1.
  - start with nbits==0: ignored. No busy, no done.
- RUN:
  - Half-counter counts 0..D (D = latched div_half), then wraps to 0.
  - On the wrap cycle, sclk toggles, edge counter increments, and the matching strobes assert in that same registered cycle.
  - Odd edges (1, 3, ...) are leading; even edges are trailing.
  - After edge 2N (N = latched nbits), go to GUARD and keep the half-counter running.
- GUARD:
  - One further half-period with sclk at idle level.
  - On its wrap: busy <= 0, done <= 1 for one cycle, return to IDLE.
- Latched configuration is immune to input changes while busy.
- start while busy is ignored.
- abort=1 in RUN or GUARD:
  - Next cycle: IDLE, busy 0, sclk = latched cpol, no done, no strobes.
  - abort takes priority over a simultaneous wrap/edge.
  - abort in IDLE has no effect.
- start and abort in the same IDLE cycle: abort wins, start ignored.
- rst mid-burst: all outputs return to reset values next cycle. No done.
- Counter widths: half-counter DIV_W bits. Edge counter CNT_W+1 bits, so 2N never overflows. D = 2^DIV_W-1 must work.

## Timing

- Let E0 be the clk edge that samples start.
- busy = 1 from E0.
- Edge k (k = 1..2N) appears on sclk at E0 + k·(D+1).
- Strobes are coincident with the sclk change, each one cycle wide.
- done pulses at E0 + (2N+1)·(D+1), the same edge at which busy falls.
- Total busy time: (2N+1)·(D+1) cycles.
- A new start is accepted in the cycle done is high (state already IDLE). Back-to-back bursts have no idle gap beyond the guard.
- D=0: sclk toggles every cycle (clk/2); strobes then assert on consecutive cycles.
- First half-period before edge 1 gives CPHA=0 setup time for the first MOSI bit.

## Test plan

- D=9, N=8, cpol=0, cpha=0, start at E0:
  - sclk rises at E0+10, falls at E0+20, ... 16 edges.
  - sample_stb on the 8 rises, shift_stb on the 8 falls.
  - done at E0+170; busy high exactly 170 cycles.
- D=0, N=1, cpol=1, cpha=1:
  - sclk 1→0 at E0+1, 0→1 at E0+2.
  - shift_stb at E0+1, sample_stb at E0+2.
  - done at E0+3.
- Idle and config guards:
  - Toggle cpol while idle: sclk follows one cycle later.
  - start with nbits=0: busy/done stay 0.
  - Change div_half/cpol mid-burst: edge timing unchanged.
- start pulsed at E0+25 during the D=9, N=8 burst: ignored. Single done at E0+170. Second start in the done cycle: new burst, first edge 10 cycles later.
- Abort cases:
  - abort at E0+45 (D=9, N=8): busy 0 at E0+46, sclk = cpol, no done, no strobe.
  - abort coincident with an edge cycle: no edge, no strobe.
- Assert rst at E0+33 mid-burst: next cycle sclk 0, busy 0, done 0, strobes 0. A subsequent start behaves as a fresh burst.
